// File: rtl/plot_framebuffer.sv
// plot_framebuffer
//
// Sink end of the pixel-plot interface fed by the drawing engines. Pixels
// presented on vga_x/vga_y/vga_colour while vga_plot is high are written
// into a WIDTH x HEIGHT framebuffer (addr = y*WIDTH + x). A clear engine
// fills the whole buffer with one colour, one pixel per cycle, and runs
// automatically out of reset with colour 0. A registered read port returns
// the stored colour one cycle after rd_en. Accepted and rejected plots are
// counted with saturating counters.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   vga_x/vga_y         plot coordinate (8 / 7 bits)
//   vga_colour          plot colour (CW bits)
//   vga_plot            plot strobe, one pixel per cycle
//   clear/clear_colour  request a full-buffer fill with clear_colour
//   busy                clear in progress, plots are rejected
//   clear_done          one-cycle pulse after the final pixel is cleared
//   rd_en/rd_x/rd_y     read request and coordinate
//   rd_valid/rd_colour  read response, one cycle after rd_en
//   plot_count          accepted plots, saturating at 32767
//   drop_count          rejected plots, saturating at 255
module plot_framebuffer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int CW     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    vga_x,
    input  logic [6:0]    vga_y,
    input  logic [CW-1:0] vga_colour,
    input  logic          vga_plot,
    input  logic          clear,
    input  logic [CW-1:0] clear_colour,
    output logic          busy,
    output logic          clear_done,
    input  logic          rd_en,
    input  logic [7:0]    rd_x,
    input  logic [6:0]    rd_y,
    output logic          rd_valid,
    output logic [CW-1:0] rd_colour,
    output logic [14:0]   plot_count,
    output logic [7:0]    drop_count
);

    localparam int          DEPTH     = WIDTH * HEIGHT;
    localparam logic [14:0] LAST_IDX  = 15'(DEPTH - 1);
    localparam logic [14:0] WIDTH15   = 15'(WIDTH);
    localparam logic [7:0]  X_LIMIT   = 8'(WIDTH);
    localparam logic [6:0]  Y_LIMIT   = 7'(HEIGHT);
    localparam logic [14:0] PLOT_MAX  = 15'h7FFF;
    localparam logic [7:0]  DROP_MAX  = 8'hFF;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    logic [CW-1:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [14:0]   idx_q, idx_d;
    logic [CW-1:0] fill_q, fill_d;
    logic [14:0]   plotCount_q, plotCount_d;
    logic [7:0]    dropCount_q, dropCount_d;
    logic          clearDone_q, clearDone_d;
    logic          rdValid_q;
    logic [CW-1:0] rdColour_q;

    logic          memWe;
    logic [14:0]   memWaddr;
    logic [CW-1:0] memWdata;

    logic          plotInRange;
    logic [14:0]   plotAddr;
    logic          rdInRange;
    logic [14:0]   rdAddr;

    assign plotInRange = (vga_x < X_LIMIT) && (vga_y < Y_LIMIT);
    assign plotAddr    = 15'(vga_y) * WIDTH15 + 15'(vga_x);
    assign rdInRange   = (rd_x < X_LIMIT) && (rd_y < Y_LIMIT);
    assign rdAddr      = 15'(rd_y) * WIDTH15 + 15'(rd_x);

    // Control state. Reset drops straight into CLEAR with colour 0 and
    // index 0, so a reset mid-operation always restarts a full black fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CLEAR;
            idx_q       <= '0;
            fill_q      <= '0;
            plotCount_q <= '0;
            dropCount_q <= '0;
            clearDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            fill_q      <= fill_d;
            plotCount_q <= plotCount_d;
            dropCount_q <= dropCount_d;
            clearDone_q <= clearDone_d;
        end
    end

    // Next-state and write-port selection. In CLEAR the fill engine owns
    // the write port and every plot is rejected; a clear request arriving
    // then is ignored so the running fill keeps its colour. In READY a clear
    // request beats a same-cycle plot: counters restart, and that plot is
    // the first drop of the new epoch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fill_d      = fill_q;
        plotCount_d = plotCount_q;
        dropCount_d = dropCount_q;
        clearDone_d = 1'b0;
        memWe       = 1'b0;
        memWaddr    = idx_q;
        memWdata    = fill_q;

        case (state_q)
            CLEAR: begin
                memWe = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d     = READY;
                    clearDone_d = 1'b1;
                end else begin
                    idx_d = idx_q + 15'd1;
                end
                if (vga_plot && (dropCount_q != DROP_MAX)) begin
                    dropCount_d = dropCount_q + 8'd1;
                end
            end
            READY: begin
                if (clear) begin
                    state_d     = CLEAR;
                    idx_d       = '0;
                    fill_d      = clear_colour;
                    plotCount_d = '0;
                    dropCount_d = {7'd0, vga_plot};
                end else if (vga_plot) begin
                    if (plotInRange) begin
                        memWe    = 1'b1;
                        memWaddr = plotAddr;
                        memWdata = vga_colour;
                        if (plotCount_q != PLOT_MAX) begin
                            plotCount_d = plotCount_q + 15'd1;
                        end
                    end else if (dropCount_q != DROP_MAX) begin
                        dropCount_d = dropCount_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    // Pixel storage: single write port, no reset (the reset fill covers it).
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memWaddr] <= memWdata;
        end
    end

    // Registered read port. Sampling the array in the same edge as a write
    // naturally yields the previous contents, giving read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdValid_q  <= 1'b0;
            rdColour_q <= '0;
        end else begin
            rdValid_q  <= rd_en;
            rdColour_q <= (rd_en && rdInRange) ? mem[rdAddr] : '0;
        end
    end

    assign busy       = (state_q == CLEAR);
    assign clear_done = clearDone_q;
    assign rd_valid   = rdValid_q;
    assign rd_colour  = rdColour_q;
    assign plot_count = plotCount_q;
    assign drop_count = dropCount_q;

endmodule
